// File: rtl/output_blk.sv
// output_blk: byte FIFO that absorbs result bursts, followed by a UART
// transmitter that serialises each word LSB first onto tx. The frame is
// 8N1: one start bit, BITS data bits and one stop bit.
// Optional even-parity bit between the data and stop bits is enabled by
// defining OUTPUT_BLK_PARITY_EN.
module output_blk #(
  parameter int BITS     = 8,
  parameter int DEPTH    = 16,
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 100_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BITS-1:0]        out_bus,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   overflow,
  output logic                   tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int AW           = $clog2(DEPTH);
  localparam int CW           = AW + 1;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(BITS - 1);
  localparam logic [CW-1:0]     COUNT_FULL = CW'(DEPTH);

`ifdef OUTPUT_BLK_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            overflow_q, overflow_d;
  logic            push;
  logic            pop;
  logic [BITS-1:0] head;

  // Transmitter
  state_t          state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            baud_end;
`ifdef OUTPUT_BLK_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign head = mem_q[rptr_q];

  // Write port of the FIFO array; contents need no reset since the
  // pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= out_bus;
    end
  end

  // FIFO next-state: full is judged on the pre-edge occupancy, so a write
  // into a full FIFO is dropped even when the FSM pops on the same edge.
  always_comb begin
    push       = wr_en & ~full_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full_q);
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == COUNT_FULL);
    empty_d = (count_d == '0);
  end

  // FIFO pointer, occupancy and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Transmitter next-state, FIFO pop and the value tx will take next cycle
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    baud_end = (baud_q == BAUD_LAST);
`ifdef OUTPUT_BLK_PARITY_EN
    parity_d = parity_q;
`endif
    // The baud counter free-runs while a frame is active and wraps on each
    // bit boundary; it sits at zero in IDLE so a new frame starts aligned.
    baud_d = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
`ifdef OUTPUT_BLK_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef OUTPUT_BLK_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef OUTPUT_BLK_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // A pending word starts its frame straight after the stop bit.
        if (baud_end) begin
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
`ifdef OUTPUT_BLK_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // tx is registered from the next state so the line never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef OUTPUT_BLK_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE) | ~empty_d;
  end

  // Transmitter registers; reset aborts any frame and returns tx high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef OUTPUT_BLK_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef OUTPUT_BLK_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_output_blk.sv
// tb_output_blk: table-driven single-frame checks, a UART receiver model
// fed by a scoreboard queue, and hand sequences for reset, back-to-back,
// overflow and pointer wrap. Build with OUTPUT_BLK_PARITY_EN for parity.
module tb_output_blk;
  localparam int BITS     = 8;
  localparam int DEPTH    = 16;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef OUTPUT_BLK_PARITY_EN
  localparam int NSLOT = BITS + 3;
`else
  localparam int NSLOT = BITS + 2;
`endif
  localparam int FR = NSLOT * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] out_bus;
  logic       wr_en;
  logic       full, empty, busy, overflow, tx;
  logic [4:0] count;

  output_blk #(
    .BITS(BITS), .DEPTH(DEPTH), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD)
  ) dut (
    .clk(clk), .rst(rst), .out_bus(out_bus), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .busy(busy),
    .overflow(overflow), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_rx  = 0;
  int cyc   = 0;
  logic rx_en = 1'b0;
  logic [7:0] sb[$];
  int starts[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Wait (bounded) until the DUT is idle and every expected byte arrived.
  task automatic wait_idle(input int budget);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain within budget", ok, 1'b1);
  endtask

  // UART receiver model: mid-bit sampling on negedges.
  initial begin
    logic [7:0] b;
    logic st, sp, pb, exp_b;
    forever begin
      @(negedge clk);
      if (rx_en && rst && tx === 1'b0) begin
        starts.push_back(cyc);
        pb = 1'b0;
        repeat (CPB / 2 - 1) @(negedge clk);
        st = tx;
        for (int i = 0; i < BITS; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
`ifdef OUTPUT_BLK_PARITY_EN
        repeat (CPB) @(negedge clk);
        pb = tx;
`endif
        repeat (CPB) @(negedge clk);
        sp = tx;
        n_rx++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx unexpected frame: got %02h expected none", b);
        end else begin
          exp_b = 1'b0;
          $display("rx frame: got %02h expected %02h", b, sb[0]);
          check("rx byte", b, sb.pop_front());
          check("rx start/stop", {st, sp}, 2'b01);
`ifdef OUTPUT_BLK_PARITY_EN
          exp_b = ^b;
          check("rx parity", pb, exp_b);
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;  // time order, MSB first: start, d0..d7, stop
    logic       par;
  } vec_t;
  vec_t vecs [7];

  initial begin
    logic [9:0] got10;
    logic       gpar;
    int         c0;

    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[2] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[3] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[4] = '{8'h81, 10'b0100000011, 1'b0};
    vecs[5] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[6] = '{8'h03, 10'b0110000001, 1'b0};

    rst = 1'b0; out_bus = '0; wr_en = 1'b0;
    // 1. reset
    repeat (5) @(negedge clk);
    check("reset tx", tx, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("post-reset tx", tx, 1'b1);
    check("post-reset empty", empty, 1'b1);
    check("post-reset full", full, 1'b0);
    check("post-reset count", count, 5'd0);
    check("post-reset busy", busy, 1'b0);
    check("post-reset overflow", overflow, 1'b0);

    // mid-frame asynchronous reset (receiver model off)
    out_bus = 8'h00; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (30) @(negedge clk);
    check("mid-frame tx low", tx, 1'b0);
    check("mid-frame busy", busy, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("async reset tx", tx, 1'b1);
    check("async reset count", count, 5'd0);
    check("async reset empty", empty, 1'b1);
    check("async reset busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rx_en = 1'b1;
    repeat (20) @(negedge clk);
    check("idle after abort", {tx, busy}, 2'b10);

    // 2. table-driven single frames
    for (int v = 0; v < 7; v++) begin
      wait_idle(500);
      out_bus = vecs[v].din; wr_en = 1'b1;
      sb.push_back(vecs[v].din);
      @(negedge clk);                 // E0 done
      wr_en = 1'b0;
      check("latency E0 count/tx", {count, tx}, {5'd1, 1'b1});
      @(negedge clk);                 // E1 done: start bit
      check("tx falls 2 edges after write", tx, 1'b0);
      repeat (CPB / 2 - 1) @(negedge clk);
      got10 = {9'b0, tx};
      gpar  = 1'b0;
      for (int i = 0; i < BITS; i++) begin
        repeat (CPB) @(negedge clk);
        got10 = {got10[8:0], tx};
      end
`ifdef OUTPUT_BLK_PARITY_EN
      repeat (CPB) @(negedge clk);
      gpar = tx;
      check("parity bit", gpar, vecs[v].par);
`endif
      repeat (CPB) @(negedge clk);
      got10 = {got10[8:0], tx};
      check("frame bits", got10, vecs[v].frame);
      repeat (FR - ((NSLOT - 1) * CPB + CPB / 2)) @(negedge clk);
      check("busy at last frame cycle", busy, 1'b1);
      @(negedge clk);
      check("busy drops after frame", busy, 1'b0);
      $display("vec %0d: byte %02h frame %b par %b", v, vecs[v].din, got10, gpar);
    end

    // 3. back-to-back frames
    wait_idle(500);
    starts.delete();
    for (int i = 0; i < 3; i++) begin
      out_bus = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h3C;
      wr_en = 1'b1;
      sb.push_back(out_bus);
      @(negedge clk);
    end
    wr_en = 1'b0;
    // first word was already popped on the edge after it landed
    check("b2b count after burst", count, 5'd2);
    wait_idle(4 * FR);
    check("b2b frame count", starts.size(), 3);
    if (starts.size() == 3) begin
      check("b2b gap 1", starts[1] - starts[0], FR);
      check("b2b gap 2", starts[2] - starts[1], FR);
    end
    $display("back-to-back: 3 frames sent");

    // 4. full / overflow
    out_bus = 8'h55; wr_en = 1'b1;
    sb.push_back(8'h55);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      out_bus = 8'h60 + 8'(i); wr_en = 1'b1;
      if (i < 16) sb.push_back(out_bus);
      @(negedge clk);
      if (i == 14) check("not yet full at 15", {full, count}, {1'b0, 5'd15});
      if (i == 15) check("full at 16", {full, count, overflow}, {1'b1, 5'd16, 1'b0});
      if (i == 16) check("overflow on 17th", {overflow, count}, {1'b1, 5'd16});
    end
    wr_en = 1'b0;
    wait_idle(20 * FR);
    check("overflow sticky", overflow, 1'b1);
    check("empty after drain", {empty, full, count}, {1'b1, 1'b0, 5'd0});
    $display("overflow: 17 writes, 16 expected frames");

    // 5. pointer wrap with a fresh reset
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("overflow cleared by reset", overflow, 1'b0);
    c0 = n_rx;
    for (int i = 0; i < 40; i++) begin
      out_bus = 8'(i); wr_en = 1'b1;
      sb.push_back(out_bus);
      @(negedge clk);
      wr_en = 1'b0;
      repeat (FR - 12) @(negedge clk);
    end
    wait_idle(20 * FR);
    check("wrap frames received", n_rx - c0, 40);
    check("wrap no overflow", overflow, 1'b0);
    $display("wrap: 40 bytes streamed");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
